// File: rtl/hram_pkg.sv
// Shared HyperBus definitions: responder state encoding, CA field positions and register map.
package hram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_WDATA,
    ST_RDATA
  } state_e;

  localparam int CA_RW_BIT = 47;
  localparam int CA_AS_BIT = 46;
  localparam int CA_BT_BIT = 45;

  localparam logic [31:0] ID0_ADDR = 32'h0000_0000;
  localparam logic [31:0] CR0_ADDR = 32'h0000_0800;
  localparam logic [15:0] ID0_VAL  = 16'h0C81;
  localparam logic [15:0] CR0_RST  = 16'h8F1F;

  // Word address is the upper column/row bits joined with the low three column bits.
  function automatic logic [31:0] ca_word_addr(input logic [47:0] ca);
    return {ca[44:16], ca[2:0]};
  endfunction

endpackage

// File: rtl/hram_resp_mem.sv
// Synchronous 16-bit RAM with per-byte write enables and a registered read port.
module hram_resp_mem #(
  parameter int DEPTH_BITS = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [1:0]            be_i,
  input  logic [DEPTH_BITS-1:0] waddr_i,
  input  logic [15:0]           wdata_i,
  input  logic [DEPTH_BITS-1:0] raddr_i,
  output logic [15:0]           rdata_o
);

  logic [7:0] mem_hi [2**DEPTH_BITS];
  logic [7:0] mem_lo [2**DEPTH_BITS];

  always_ff @(posedge clk_i) begin
    if (we_i && be_i[1]) mem_hi[waddr_i] <= wdata_i[15:8];
    if (we_i && be_i[0]) mem_lo[waddr_i] <= wdata_i[7:0];
    rdata_o <= {mem_hi[raddr_i], mem_lo[raddr_i]};
  end

endmodule

// File: rtl/hram_resp.sv
// HyperBus target model: CA decode, fixed 2x latency, linear bursts into an internal RAM.
// Define HRAM_RESP_REGS_EN to implement the ID0/CR0 register space.
module hram_resp
  import hram_pkg::*;
#(
  parameter int DEPTH_BITS = 10,
  parameter int LATENCY    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ck,
  input  logic        ce,
  input  logic [15:0] adq_i,
  output logic [15:0] adq_o,
  output logic        adq_oe,
  input  logic [1:0]  dqs_i,
  output logic [1:0]  dqs_o,
  output logic        dqs_oe
);

  localparam logic [7:0] LAT_LAST = 8'(4 * LATENCY - 1);

  state_e                state_q;
  logic                  ck_q;
  logic [1:0]            ca_cnt_q;
  logic [15:0]           ca_hi_q;
  logic [15:0]           ca_mid_q;
  logic                  is_read_q;
  logic                  is_reg_q;
  logic [DEPTH_BITS-1:0] addr_q;
  logic [7:0]            lat_cnt_q;
  logic                  edge_w;
  logic [47:0]           ca_full;
  logic [31:0]           ca_addr;
  logic                  mem_we;
  logic [15:0]           mem_rdata;
  logic [15:0]           rd_word;
  logic                  unused_ca;

  assign edge_w    = ck ^ ck_q;
  assign ca_full   = {ca_hi_q, ca_mid_q, adq_i};
  assign ca_addr   = ca_word_addr(ca_full);
  assign unused_ca = ^{ca_full[CA_BT_BIT], ca_full[15:3], ca_addr};
  assign mem_we    = (state_q == ST_WDATA) && edge_w && !ce && !is_reg_q;

  // The read port always tracks addr_q, so the next word is ready before the following edge.
  hram_resp_mem #(.DEPTH_BITS(DEPTH_BITS)) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .be_i    (~dqs_i),
    .waddr_i (addr_q),
    .wdata_i (adq_i),
    .raddr_i (addr_q),
    .rdata_o (mem_rdata)
  );

`ifdef HRAM_RESP_REGS_EN
  logic        reg_id0_q;
  logic        reg_cr0_q;
  logic [15:0] cr0_q;

  assign rd_word = !is_reg_q ? mem_rdata :
                   reg_id0_q ? ID0_VAL   :
                   reg_cr0_q ? cr0_q     : 16'h0000;

  // Register hits are only meaningful for the first word of a register burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_id0_q <= 1'b0;
      reg_cr0_q <= 1'b0;
      cr0_q     <= CR0_RST;
    end else if (!ce && edge_w) begin
      if (state_q == ST_CA && ca_cnt_q == 2'd2) begin
        reg_id0_q <= (ca_addr == ID0_ADDR);
        reg_cr0_q <= (ca_addr == CR0_ADDR);
      end else if (state_q == ST_WDATA || state_q == ST_RDATA) begin
        if (state_q == ST_WDATA && is_reg_q && reg_cr0_q) cr0_q <= adq_i;
        reg_id0_q <= 1'b0;
        reg_cr0_q <= 1'b0;
      end
    end
  end
`else
  assign rd_word = is_reg_q ? 16'h0000 : mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ck_q      <= 1'b0;
      ca_cnt_q  <= 2'd0;
      ca_hi_q   <= 16'h0000;
      ca_mid_q  <= 16'h0000;
      is_read_q <= 1'b0;
      is_reg_q  <= 1'b0;
      addr_q    <= '0;
      lat_cnt_q <= 8'd0;
      adq_o     <= 16'h0000;
      adq_oe    <= 1'b0;
      dqs_o     <= 2'b00;
      dqs_oe    <= 1'b0;
    end else begin
      ck_q <= ck;
      if (ce) begin
        state_q <= ST_IDLE;
        adq_oe  <= 1'b0;
        dqs_oe  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q  <= ST_CA;
            ca_cnt_q <= 2'd0;
            dqs_oe   <= 1'b1;
            dqs_o    <= 2'b11;
          end
          ST_CA: if (edge_w) begin
            if (ca_cnt_q == 2'd0) begin
              ca_hi_q  <= adq_i;
              ca_cnt_q <= 2'd1;
            end else if (ca_cnt_q == 2'd1) begin
              ca_mid_q <= adq_i;
              ca_cnt_q <= 2'd2;
            end else begin
              is_read_q <= ca_full[CA_RW_BIT];
              is_reg_q  <= ca_full[CA_AS_BIT];
              addr_q    <= ca_addr[DEPTH_BITS-1:0];
              lat_cnt_q <= 8'd0;
              // Register writes skip the latency phase entirely.
              if (ca_full[CA_AS_BIT] && !ca_full[CA_RW_BIT]) begin
                state_q <= ST_WDATA;
                dqs_oe  <= 1'b0;
              end else begin
                state_q <= ST_LAT;
                dqs_oe  <= ca_full[CA_RW_BIT];
                dqs_o   <= 2'b00;
              end
            end
          end
          ST_LAT: if (edge_w) begin
            if (lat_cnt_q == LAT_LAST) begin
              state_q <= is_read_q ? ST_RDATA : ST_WDATA;
              adq_oe  <= is_read_q;
            end else begin
              lat_cnt_q <= lat_cnt_q + 8'd1;
            end
          end
          ST_WDATA: if (edge_w) begin
            addr_q <= addr_q + 1'b1;
          end
          ST_RDATA: if (edge_w) begin
            adq_o  <= rd_word;
            dqs_o  <= ~dqs_o;
            addr_q <= addr_q + 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hram_resp.sv
// Self-checking bench for hram_resp: directed protocol steps plus random bursts against a word-array model.
module tb_hram_resp;

  localparam int DEPTH_BITS = 10;
  localparam int LATENCY    = 6;
  localparam int WORDS      = 1 << DEPTH_BITS;
  localparam int LAT_EDGES  = 4 * LATENCY;

  logic        clk = 1'b0;
  logic        rst;
  logic        ck;
  logic        ce;
  logic [15:0] adq_i;
  logic [15:0] adq_o;
  logic        adq_oe;
  logic [1:0]  dqs_i;
  logic [1:0]  dqs_o;
  logic        dqs_oe;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] model [WORDS];
  logic [15:0] cr0Model;
  logic [15:0] wrData [$];
  logic [1:0]  wrMask [$];
  logic [15:0] rdWords [$];

  always #5 clk = ~clk;

  hram_resp #(.DEPTH_BITS(DEPTH_BITS), .LATENCY(LATENCY)) dut (
    .clk    (clk),
    .rst    (rst),
    .ck     (ck),
    .ce     (ce),
    .adq_i  (adq_i),
    .adq_o  (adq_o),
    .adq_oe (adq_oe),
    .dqs_i  (dqs_i),
    .dqs_o  (dqs_o),
    .dqs_oe (dqs_oe)
  );

  // Guards against a stuck run; every other wait is a fixed number of cycles.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Toggles ck once with the given bus values; returns on a falling clk edge two cycles later.
  task automatic applyStimulus(input logic [15:0] d, input logic [1:0] m);
    adq_i = d;
    dqs_i = m;
    ck    = ~ck;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
  endtask

  function automatic logic [15:0] regExpect(input logic [31:0] a);
`ifdef HRAM_RESP_REGS_EN
    if (a == 32'h0000_0000) return 16'h0C81;
    if (a == 32'h0000_0800) return cr0Model;
`endif
    return 16'h0000;
  endfunction

  task automatic beginCommand(input logic rd, input logic regSp, input logic [31:0] a);
    logic [47:0] ca;
    ca = {rd, regSp, 1'b1, a[31:3], 13'h0000, a[2:0]};
    ce = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("dqs_oe in CA", {15'h0, dqs_oe}, 16'h0001);
    applyStimulus(ca[47:32], 2'b00);
    applyStimulus(ca[31:16], 2'b00);
    checkOutput("dqs_o in CA", {14'h0, dqs_o}, 16'h0003);
    applyStimulus(ca[15:0], 2'b00);
  endtask

  task automatic endCommand();
    ce = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("adq_oe after ce high", {15'h0, adq_oe}, 16'h0000);
    checkOutput("dqs_oe after ce high", {15'h0, dqs_oe}, 16'h0000);
  endtask

  task automatic writeBurst(input logic regSp, input logic [31:0] a);
    int w;
    w = int'(a % WORDS);
    beginCommand(1'b0, regSp, a);
    if (!regSp) repeat (LAT_EDGES) applyStimulus(16'($urandom), 2'($urandom));
    for (int i = 0; i < wrData.size(); i++) begin
      applyStimulus(wrData[i], wrMask[i]);
      if (!regSp) begin
        model[w] = {wrMask[i][1] ? model[w][15:8] : wrData[i][15:8],
                    wrMask[i][0] ? model[w][7:0]  : wrData[i][7:0]};
        w = (w + 1) % WORDS;
      end
`ifdef HRAM_RESP_REGS_EN
      else if (i == 0 && a == 32'h0000_0800) cr0Model = wrData[i];
`endif
    end
    endCommand();
  endtask

  task automatic readBurst(input logic regSp, input logic [31:0] a, input int n, input string tag);
    int w;
    w = int'(a % WORDS);
    rdWords.delete();
    beginCommand(1'b1, regSp, a);
    repeat (LAT_EDGES) applyStimulus(16'($urandom), 2'b00);
    for (int i = 0; i < n; i++) begin
      applyStimulus(16'($urandom), 2'b00);
      rdWords.push_back(adq_o);
      checkOutput(tag, adq_o, regSp ? regExpect(a) : model[w]);
      checkOutput("dqs_o toggle", {14'h0, dqs_o}, (i % 2 == 0) ? 16'h0003 : 16'h0000);
      checkOutput("adq_oe in data", {15'h0, adq_oe}, 16'h0001);
      checkOutput("dqs_oe in data", {15'h0, dqs_oe}, 16'h0001);
      w = (w + 1) % WORDS;
    end
    endCommand();
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    ce  = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    cr0Model = 16'h8F1F;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int a;
    int n;
    rst = 1'b1; ck = 1'b0; ce = 1'b1; adq_i = 16'h0000; dqs_i = 2'b00;
    cr0Model = 16'h8F1F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset adq_o",  adq_o, 16'h0000);
    checkOutput("reset adq_oe", {15'h0, adq_oe}, 16'h0000);
    checkOutput("reset dqs_o",  {14'h0, dqs_o}, 16'h0000);
    checkOutput("reset dqs_oe", {15'h0, dqs_oe}, 16'h0000);

    $display("[TB] fill memory with random words");
    wrData.delete(); wrMask.delete();
    for (int i = 0; i < WORDS; i++) begin
      wrData.push_back(16'($urandom));
      wrMask.push_back(2'b00);
    end
    writeBurst(1'b0, 32'd0);

    $display("[TB] write burst and masked write");
    wrData = '{16'h1234, 16'h5678}; wrMask = '{2'b00, 2'b00};
    writeBurst(1'b0, 32'd0);
    wrData = '{16'hAAAA}; wrMask = '{2'b10};
    writeBurst(1'b0, 32'd0);
    readBurst(1'b0, 32'd0, 2, "read burst");
    checkOutput("masked word 0", rdWords[0], 16'h12AA);
    checkOutput("burst word 1",  rdWords[1], 16'h5678);

    $display("[TB] address wrap");
    wrData = '{16'hC0DE, 16'hBEEF}; wrMask = '{2'b00, 2'b00};
    writeBurst(1'b0, 32'h3FF);
    readBurst(1'b0, 32'h000, 1, "wrap word at 0");
    checkOutput("wrap constant", rdWords[0], 16'hBEEF);
    readBurst(1'b0, 32'h3FF, 2, "wrap read across end");

    $display("[TB] abort after one word then immediate new command");
    readBurst(1'b0, 32'h3FF, 1, "abort read");
    readBurst(1'b0, 32'h001, 1, "read after abort");

    $display("[TB] register space");
`ifdef HRAM_RESP_REGS_EN
    readBurst(1'b1, 32'h0000_0000, 1, "ID0 read");
    checkOutput("ID0 constant", rdWords[0], 16'h0C81);
    readBurst(1'b1, 32'h0000_0800, 1, "CR0 reset read");
    wrData = '{16'h8F17}; wrMask = '{2'b00};
    writeBurst(1'b1, 32'h0000_0800);
    readBurst(1'b1, 32'h0000_0800, 1, "CR0 readback");
    checkOutput("CR0 constant", rdWords[0], 16'h8F17);
    pulseReset();
    readBurst(1'b1, 32'h0000_0800, 1, "CR0 after reset");
    checkOutput("CR0 reset constant", rdWords[0], 16'h8F1F);
`else
    readBurst(1'b1, 32'h0000_0800, 1, "reg read zero");
    wrData = '{16'h8F17}; wrMask = '{2'b00};
    writeBurst(1'b1, 32'h0000_0800);
    readBurst(1'b1, 32'h0000_0800, 1, "reg write dropped");
`endif
    readBurst(1'b0, 32'h000, 1, "mem untouched by reg write");

    $display("[TB] reset in the middle of a read");
    beginCommand(1'b1, 1'b0, 32'd0);
    repeat (LAT_EDGES) applyStimulus(16'h0000, 2'b00);
    applyStimulus(16'h0000, 2'b00);
    pulseReset();
    checkOutput("mid reset adq_o",  adq_o, 16'h0000);
    checkOutput("mid reset adq_oe", {15'h0, adq_oe}, 16'h0000);
    checkOutput("mid reset dqs_o",  {14'h0, dqs_o}, 16'h0000);
    checkOutput("mid reset dqs_oe", {15'h0, dqs_oe}, 16'h0000);
    readBurst(1'b0, 32'h000, 2, "memory persists");

    $display("[TB] random bursts");
    for (int it = 0; it < 24; it++) begin
      a = $urandom_range(WORDS - 1);
      n = $urandom_range(6, 1);
      if ($urandom_range(1, 0) == 1) begin
        wrData.delete(); wrMask.delete();
        for (int k = 0; k < n; k++) begin
          wrData.push_back(16'($urandom));
          wrMask.push_back(2'($urandom));
        end
        writeBurst(1'b0, 32'(a));
      end else begin
        readBurst(1'b0, 32'(a), n, "random read");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hram_resp.md
# hram_resp

Synthesizable HyperBus target (HyperRAM device model) that sits on the far end of the `hram` controller's `adq`/`dqs`/`ck`/`ce` pins. It decodes the 48-bit command/address, applies fixed initial latency, and serves linear read/write bursts from an internal 16-bit-wide memory. It is used in simulation benches and on FPGA loopback builds to exercise `hram` without a physical part. `ck` is oversampled in the `clk` domain; the controller toggles `ck` at most once every 2 `clk` cycles.

## Interface
- `DEPTH_BITS`, 10: word-address width; memory is 2^DEPTH_BITS × 16 bit.
- `LATENCY`, 6: initial latency in `ck` cycles; always doubled, since fixed 2× latency is signalled.
- `clk` in 1: system clock; sole clock.
- `rst` in 1: synchronous, active-high reset.
- `ck` in 1: HyperBus clock from controller, sampled on `clk`.
- `ce` in 1: chip select, active-low (idle high).
- `adq_i` in 16: address/data from controller.
- `adq_o` out 16: read data to controller.
- `adq_oe` out 1: drive enable for `adq_o`.
- `dqs_i` in 2: write mask from controller (bit1 = upper byte, bit0 = lower byte; 1 = masked).
- `dqs_o` out 2: RWDS driven by responder.
- `dqs_oe` out 1: drive enable for `dqs_o`.

## Operation
- Edge detect: `ck_q` is `ck` registered; `edge = ck ^ ck_q`. All protocol actions occur on `clk` cycles where `edge` = 1 and `ce` = 0.
- States: IDLE, CA, LAT, WDATA, RDATA.
- IDLE → CA on `ce` falling (registered). In CA, three edges capture CA[47:32], CA[31:16], CA[15:0]. During CA, `dqs_oe` = 1 and `dqs_o` = 2'b11, signalling 2× latency.
- Decode: CA[47] = 1 read / 0 write; CA[46] = 1 register space; CA[45] burst type, ignored (all bursts linear). Word address = {CA[44:16], CA[2:0]} truncated to DEPTH_BITS.
- After the 3rd CA edge: a memory write goes to LAT; a memory read goes to LAT; a register write goes directly to WDATA (zero latency).
- LAT counts 4·LATENCY edges, then enters WDATA or RDATA.
- WDATA: each edge writes `adq_i` to mem[addr] with byte enables `~dqs_i`, then addr+1.
- RDATA: each edge sets `adq_o` = mem[addr] and toggles `dqs_o` (both bits; first word drives 2'b11), then addr+1. `adq_oe` = `dqs_oe` = 1 throughout RDATA.
- Address wraps modulo 2^DEPTH_BITS.
- `ce` high in any state → IDLE on the next `clk`: `adq_oe`, `dqs_oe` = 0, and any partial burst is abandoned. Words already written persist.
- `ce` low with no edges: the state holds indefinitely.

## Timing
- Reset values: state IDLE, `adq_o` 0, `adq_oe` 0, `dqs_o` 0, `dqs_oe` 0, `ck_q` 0. Memory contents are not reset.
- Read output is registered: `adq_o`/`dqs_o` change 1 `clk` after the `ck` edge is sampled, i.e. 2 `clk` after `ck` toggles. The controller samples at least 1 `clk` later.
- Write sample: `adq_i`/`dqs_i` are taken in the same `clk` cycle that `edge` is seen.
- `rst` overrides all other inputs, including mid-burst.

## Configuration
- `HRAM_RESP_REGS_EN` defined:
  - Register space is implemented. Reads of ID0 (CA addr 0x000000) return 16'h0C81; reads of CR0 (0x000800) return the CR0 register, reset 16'h8F1F.
  - Register writes to CR0 are stored; writes to other addresses are dropped.
- Undefined: register-space reads return 16'h0000 with normal latency; register writes are dropped but still consume the burst.

## Structure
- `hram_pkg`: state enum, CA field bit positions, ID0/CR0 addresses and reset values. Shared with `hram`.
- Sub-module `hram_resp_mem`: 2^DEPTH_BITS × 16 synchronous RAM with 2-bit byte enable and 1-cycle read. The FSM prefetches the next word so that RDATA sustains one word per edge.

## Test plan
- Write burst: CA write to addr 0, words 16'h1234, 16'h5678, `dqs_i` = 2'b00, `ce` high → mem[0] = 16'h1234, mem[1] = 16'h5678.
- Masked write: write 16'hAAAA to addr 0 with `dqs_i` = 2'b10 → mem[0] = 16'h12AA.
- Read burst: read addr 0, 2 words → after exactly 4·LATENCY = 24 edges post-CA, `adq_o` = 16'h12AA then 16'h5678. `dqs_o` toggles on each word and `dqs_oe` = 1 during CA and data.
- Wrap: with DEPTH_BITS = 10, write at 0x3FF then one more word → second word lands at 0x000.
- Abort: deassert `ce` after 1 read word → `adq_oe` = 0 next `clk`. State is IDLE, and a new CA is accepted immediately.
- Registers (`HRAM_RESP_REGS_EN`): read ID0 → 16'h0C81. Write CR0 = 16'h8F17 (no latency), read back → 16'h8F17. Assert `rst` → CR0 = 16'h8F1F.
